// File: rtl/qa_pattern_source_pkg.sv
// Shared definitions for the QA pattern source: register map, encodings and
// the pattern/LFSR helper functions used by the top and the LFSR sub-module.
package qa_pattern_source_pkg;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_PERIOD = 1;
    localparam int unsigned REG_SEED   = 2;
    localparam int unsigned REG_NUM    = 3;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] TOGGLE_A  = 32'h7FFF_8001;
    localparam logic [31:0] TOGGLE_B  = 32'h8001_7FFF;

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [31:0] pattern_word(input mode_e       mode,
                                                 input logic [15:0] idx,
                                                 input logic [31:0] seed,
                                                 input logic [31:0] lfsr);
        logic [31:0] word;
        case (mode)
            MODE_RAMP:   word = {idx, ~idx};
            MODE_CONST:  word = seed;
            MODE_LFSR:   word = lfsr;
            default:     word = idx[0] ? TOGGLE_B : TOGGLE_A;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/qa_pattern_source_lfsr32.sv
// 32-bit Fibonacci LFSR. load+advance together loads the seed already stepped
// once, because the seed itself is emitted directly as the first sample.
module qa_lfsr32
    import qa_pattern_source_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= 32'd1;
        end else if (load) begin
            state <= advance ? lfsr_step(fix_seed(seed)) : fix_seed(seed);
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures the bus data when its address is written
// and pulses `changed` for one cycle afterwards.
module setting_reg #(
    parameter int                my_addr  = 0,
    parameter int                awidth   = 8,
    parameter int                width    = 32,
    parameter logic [width-1:0]  at_reset = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [awidth-1:0] addr,
    input  logic [31:0]       in,
    output logic [width-1:0]  out,
    output logic              changed
);

    localparam logic [awidth-1:0] ADDR = awidth'(my_addr);

    logic unused_in;
    assign unused_in = ^in;

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= at_reset;
            changed <= 1'b0;
        end else if (strobe && (addr == ADDR)) begin
            out     <= in[width-1:0];
            changed <= 1'b1;
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/qa_pattern_source.sv
// Settings-bus programmed test-pattern transmitter driving the strobed
// sample interface (ramp / constant / LFSR / full-scale toggle).
module qa_pattern_source
    import qa_pattern_source_pkg::*;
#(
    parameter int BASE         = 0,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    output logic [31:0] sample,
    output logic        strobe,
    output logic        run,
    output logic [31:0] count
);

    localparam logic [7:0] CTRL_ADDR = 8'(BASE + REG_CTRL);

    logic                    settings_rst;
    logic [2:0]              ctrl_reg;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic [31:0]             seed_reg;
    logic [31:0]             num_reg;
    logic [3:0]              chg;

    assign settings_rst = ~reset;

    setting_reg #(.my_addr(BASE + REG_CTRL), .width(3)) u_ctrl (
        .clk(clk), .rst(settings_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(ctrl_reg), .changed(chg[0])
    );

    setting_reg #(.my_addr(BASE + REG_PERIOD), .width(PERIOD_WIDTH)) u_period (
        .clk(clk), .rst(settings_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(period_reg), .changed(chg[1])
    );

    setting_reg #(.my_addr(BASE + REG_SEED), .width(32)) u_seed (
        .clk(clk), .rst(settings_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(seed_reg), .changed(chg[2])
    );

    setting_reg #(.my_addr(BASE + REG_NUM), .width(32)) u_num (
        .clk(clk), .rst(settings_rst), .strobe(set_stb), .addr(set_addr),
        .in(set_data), .out(num_reg), .changed(chg[3])
    );

    // Enable is taken straight from the bus so a stop acts one cycle earlier
    // than a start, which has to wait for the settings registers to update.
    logic unused_ok;
    assign unused_ok = ^{ctrl_reg[0], chg};

    logic ctrl_wr;
    assign ctrl_wr = set_stb && (set_addr == CTRL_ADDR);

    state_e                  state;
    mode_e                   mode_act;
    logic [PERIOD_WIDTH-1:0] period_act;
    logic [PERIOD_WIDTH-1:0] pcnt;
    logic [31:0]             seed_act;
    logic [31:0]             num_act;
    logic [31:0]             n_issued;
    logic                    start_p1;
    logic [31:0]             lfsr_q;
    logic                    start_go;
    logic                    fire;

    assign start_go = start_p1 && !ctrl_wr;
    assign fire     = (state == ST_RUN) && !start_p1 && !ctrl_wr && (pcnt == '0)
                      && !((num_act != 32'd0) && (n_issued == num_act));

    qa_lfsr32 u_lfsr (
        .clk(clk),
        .reset(reset),
        .load(start_go),
        .advance(start_go || fire),
        .seed(seed_reg),
        .state(lfsr_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            strobe     <= 1'b0;
            sample     <= '0;
            count      <= '0;
            start_p1   <= 1'b0;
            pcnt       <= '0;
            n_issued   <= '0;
            mode_act   <= MODE_RAMP;
            period_act <= '0;
            seed_act   <= '0;
            num_act    <= '0;
        end else begin
            strobe <= 1'b0;
            if (strobe && (count != '1)) begin
                count <= count + 32'd1;
            end

            if (ctrl_wr) begin
                // A CTRL write always wins over a strobe due this cycle.
                start_p1 <= set_data[0];
                if (!set_data[0]) begin
                    state <= ST_IDLE;
                    run   <= 1'b0;
                end
            end else if (start_p1) begin
                start_p1   <= 1'b0;
                state      <= ST_RUN;
                run        <= 1'b1;
                strobe     <= 1'b1;
                sample     <= pattern_word(mode_e'(ctrl_reg[2:1]), 16'd0, seed_reg,
                                           fix_seed(seed_reg));
                count      <= '0;
                n_issued   <= 32'd1;
                pcnt       <= period_reg;
                mode_act   <= mode_e'(ctrl_reg[2:1]);
                period_act <= period_reg;
                seed_act   <= seed_reg;
                num_act    <= num_reg;
            end else if (state == ST_RUN) begin
                if (strobe && (num_act != 32'd0) && (count + 32'd1 == num_act)) begin
                    state <= ST_DONE;
                    run   <= 1'b0;
                end else if (fire) begin
                    strobe   <= 1'b1;
                    sample   <= pattern_word(mode_act, n_issued[15:0], seed_act, lfsr_q);
                    n_issued <= n_issued + 32'd1;
                    pcnt     <= period_act;
                end else if (pcnt != '0) begin
                    pcnt <= pcnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qa_pattern_source.sv
// Directed bench for qa_pattern_source: a cycle-indexed reference model of the
// strobe schedule and patterns, checked every cycle, plus hand-computed pins.
module tb_qa_pattern_source;

    localparam int BASE = 0;
    localparam int PW   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] sample;
    logic        strobe;
    logic        run;
    logic [31:0] count;

    qa_pattern_source #(.BASE(BASE), .PERIOD_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .sample(sample), .strobe(strobe), .run(run),
        .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, need 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Shadow of the programmed registers and the active run window.
    int          sh_period = 0;
    logic [31:0] sh_seed = '0;
    longint      sh_num = 0;
    bit          w_valid = 1'b0;
    int          w_first = 0;
    int          w_stop = 0;
    int          w_P = 0;
    int          w_mode = 0;
    longint      w_num = 0;
    logic [31:0] w_seed = '0;
    int          gap = -1;
    bit          gap_run = 1'b0;
    logic [31:0] hold = '0;
    logic [31:0] lfsr_tab [2048];

    bit          mon_en = 1'b0;
    bit          cap_en = 1'b0;
    int          cap_cyc [$];
    logic [31:0] cap_val [$];
    int          last_w = 0;

    function automatic int m_idx(input int t);
        int k;
        if (!w_valid || t < w_first || t >= w_stop) return -1;
        if ((t - w_first) % (w_P + 1) != 0) return -1;
        k = (t - w_first) / (w_P + 1);
        if (w_num != 0 && longint'(k) >= w_num) return -1;
        return k;
    endfunction

    function automatic logic [31:0] m_pat(input int k);
        logic [15:0] i16;
        i16 = k[15:0];
        case (w_mode)
            0: return {i16, ~i16};
            1: return w_seed;
            2: return (k < 2048) ? lfsr_tab[k] : 32'h0;
            default: return i16[0] ? 32'h8001_7FFF : 32'h7FFF_8001;
        endcase
    endfunction

    function automatic bit m_run(input int t);
        if (!w_valid || t < w_first || t >= w_stop) return 1'b0;
        if (w_num != 0 && longint'(t) > longint'(w_first) + (w_num - 1) * longint'(w_P + 1))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint m_count(input int t);
        longint e;
        longint n;
        if (!w_valid) return 0;
        e = (t < w_stop) ? t : w_stop;
        if (e <= w_first) return 0;
        n = (e - 1 - w_first) / (w_P + 1) + 1;
        if (w_num != 0 && n > w_num) n = w_num;
        return n;
    endfunction

    task automatic model_ctrl(input int w, input logic [31:0] d);
        logic [31:0] s;
        if (d[0]) begin
            gap_run = m_run(w);
            gap     = w + 1;
            w_valid = 1'b1;
            w_first = w + 2;
            w_stop  = 32'h7FFF_FFFF;
            w_P     = sh_period;
            w_num   = sh_num;
            w_mode  = int'(d[2:1]);
            w_seed  = sh_seed;
            s = (sh_seed == 32'd0) ? 32'd1 : sh_seed;
            for (int i = 0; i < 2048; i++) begin
                lfsr_tab[i] = s;
                s = {s[30:0], ^(s & 32'h8020_0003)};
            end
        end else if (w_valid && w_stop > w + 1) begin
            w_stop = w + 1;
        end
    endtask

    always @(negedge clk) begin
        int          k;
        logic [31:0] es;
        if (reset && mon_en) begin
            k  = m_idx(cyc);
            es = (k >= 0) ? m_pat(k) : hold;
            chk("strobe", 32'(strobe), 32'(k >= 0));
            chk("sample", sample, es);
            chk("run", 32'(run), 32'((cyc == gap) ? gap_run : m_run(cyc)));
            if (cyc != gap) chk("count", count, 32'(m_count(cyc)));
            hold = es;
        end
        if (reset && cap_en && strobe) begin
            cap_cyc.push_back(cyc);
            cap_val.push_back(sample);
        end
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_raw(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        last_w   = cyc;
        @(posedge clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        int w;
        w = cyc;
        wr_raw(8'(BASE + off), d);
        case (off)
            1:       sh_period = int'(d[PW-1:0]);
            2:       sh_seed = d;
            3:       sh_num = longint'(d);
            default: model_ctrl(w, d);
        endcase
    endtask

    task automatic cap_clear();
        cap_cyc.delete();
        cap_val.delete();
    endtask

    function automatic logic [31:0] cval(input int i);
        return (i < cap_val.size()) ? cap_val[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int ccyc(input int i);
        return (i < cap_cyc.size()) ? cap_cyc[i] : -1000;
    endfunction

    logic [31:0] ramp_exp [5];
    logic [31:0] lfsr_first [1000];

    initial begin
        int target;
        int diffs;
        int first;
        ramp_exp[0] = 32'h0000_FFFF;
        ramp_exp[1] = 32'h0001_FFFE;
        ramp_exp[2] = 32'h0002_FFFD;
        ramp_exp[3] = 32'h0003_FFFC;
        ramp_exp[4] = 32'h0004_FFFB;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_sample", sample, 32'h0);
        chk("reset_strobe", 32'(strobe), 32'h0);
        chk("reset_run", 32'(run), 32'h0);
        chk("reset_count", count, 32'h0);
        reset = 1'b1;
        mon_en = 1'b1;
        cap_en = 1'b1;
        step(2);

        // Out-of-range addresses must not start anything.
        cap_clear();
        wr_raw(8'(BASE + 4), 32'h1);
        wr_raw(8'hFF, 32'h1);
        step(6);
        chk("oob_strobes", 32'(cap_cyc.size()), 32'd0);

        // Ramp, PERIOD=3, NUM=5.
        wr(1, 32'd3);
        wr(3, 32'd5);
        cap_clear();
        wr(0, 32'h1);
        step(25);
        chk("ramp_nstrobes", 32'(cap_cyc.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("ramp_cycle", 32'(ccyc(i)), 32'(last_w + 2 + 4 * i));
            chk("ramp_value", cval(i), ramp_exp[i]);
        end
        chk("ramp_done_run", 32'(run), 32'h0);
        chk("ramp_done_count", count, 32'd5);

        // Constant, every cycle, then stop.
        wr(1, 32'd0);
        wr(2, 32'hDEAD_BEEF);
        wr(3, 32'd0);
        cap_clear();
        wr(0, 32'h3);
        step(10);
        chk("const_value", cval(5), 32'hDEAD_BEEF);
        chk("const_spacing", 32'(ccyc(6) - ccyc(5)), 32'd1);
        wr(0, 32'h0);
        chk("stop_run", 32'(run), 32'h0);
        chk("stop_strobe", 32'(strobe), 32'h0);
        cap_clear();
        step(6);
        chk("stop_no_strobe", 32'(cap_cyc.size()), 32'd0);

        // LFSR from seed 0, 1000 samples, then rerun.
        wr(2, 32'd0);
        wr(3, 32'd1000);
        cap_clear();
        wr(0, 32'h5);
        step(1010);
        chk("lfsr_nstrobes", 32'(cap_val.size()), 32'd1000);
        chk("lfsr_s0", cval(0), 32'h0000_0001);
        chk("lfsr_s1", cval(1), 32'h0000_0003);
        chk("lfsr_s2", cval(2), 32'h0000_0006);
        chk("lfsr_s3", cval(3), 32'h0000_000D);
        for (int i = 0; i < 1000; i++) lfsr_first[i] = cval(i);
        cap_clear();
        wr(0, 32'h5);
        step(1010);
        diffs = 0;
        for (int i = 0; i < 1000; i++) if (cval(i) !== lfsr_first[i]) diffs++;
        chk("lfsr_rerun_diffs", 32'(diffs), 32'd0);

        // Ramp P=2, PERIOD rewritten mid-run, restart on a strobe cycle.
        wr(1, 32'd2);
        wr(3, 32'd0);
        wr(0, 32'h1);
        step(3);
        wr(1, 32'd5);
        cap_clear();
        step(10);
        chk("rewrite_spacing", 32'(ccyc(1) - ccyc(0)), 32'd3);
        target = ccyc(cap_cyc.size() - 1) + 2;
        while (target < cyc) target += 3;
        step(target - cyc);
        wr(0, 32'h1);
        chk("suppress_strobe", 32'(strobe), 32'h0);
        step(1);
        chk("restart_strobe", 32'(strobe), 32'h1);
        chk("restart_sample", sample, 32'h0000_FFFF);
        cap_clear();
        step(20);
        chk("new_spacing", 32'(ccyc(1) - ccyc(0)), 32'd6);

        // Continuous ramp across the 16-bit wrap.
        cap_en = 1'b0;
        wr(1, 32'd0);
        wr(0, 32'h1);
        first = last_w + 2;
        step(first + 65535 - cyc);
        chk("wrap_pre", sample, 32'hFFFF_0000);
        step(1);
        chk("wrap_strobe", 32'(strobe), 32'h1);
        chk("wrap_sample", sample, 32'h0000_FFFF);
        wr(0, 32'h0);
        chk("wrap_count", count, 32'd65537);
        cap_en = 1'b1;

        // Reset mid-run.
        wr(1, 32'd1);
        wr(0, 32'h1);
        step(7);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_sample", sample, 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_run", 32'(run), 32'h0);
        chk("rst_count", count, 32'h0);
        w_valid = 1'b0;
        gap = -1;
        hold = '0;
        sh_period = 0;
        sh_seed = '0;
        sh_num = 0;
        cap_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(10);
        chk("post_rst_strobes", 32'(cap_cyc.size()), 32'd0);
        wr(0, 32'h1);
        step(6);
        chk("post_rst_restart", cval(0), 32'h0000_FFFF);
        wr(0, 32'h0);
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qa_pattern_source.md
# qa_pattern_source

Test-pattern transmitter for the strobed sample interface (32-bit `sample` qualified by a one-cycle `strobe`) consumed by the RX framing chain. It generates ramp, constant, LFSR or full-scale-toggle I/Q words at a programmable strobe period. It is programmed over the settings bus and replaces the radio front end during QA builds, so the RX path and host can be checked bit-exactly.

## Interface
- `BASE`, 0: first settings-bus address; occupies BASE..BASE+3.
- `PERIOD_WIDTH`, 16: width of the strobe period register.
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `set_stb`  in  1: settings write strobe.
- `set_addr`  in  8: settings address.
- `set_data`  in  32: settings data.
- `sample`  out  32: {I[15:0], Q[15:0]}; valid when `strobe` is high.
- `strobe`  out  1: one-cycle sample qualifier.
- `run`  out  1: high while the source is in state RUN.
- `count`  out  32: number of samples emitted since the last start; saturates at 0xFFFF_FFFF.

## Operation
Registers (all reset to 0):
- BASE+0 CTRL: bit0 enable; bits[2:1] mode (0 ramp, 1 constant, 2 LFSR, 3 toggle). Any write to CTRL restarts the source.
- BASE+1 PERIOD[PERIOD_WIDTH-1:0]: one strobe every PERIOD+1 cycles; 0 means every cycle.
- BASE+2 SEED: constant value (mode 1) or LFSR seed (mode 2). Seed 0 is replaced by 1.
- BASE+3 NUM: samples to emit; 0 means continuous.

States:
- IDLE: outputs quiet. A CTRL write with enable=1 moves to RUN; it clears `count`, the period counter and the pattern state.
- RUN:
  - A strobe fires when the period counter reaches 0; the counter then reloads with PERIOD.
  - When NUM≠0 and `count` reaches NUM, the source moves to DONE on the cycle after the last strobe.
  - A CTRL write with enable=0 moves to IDLE immediately. Any in-flight period is abandoned and no further strobe fires.
  - A CTRL write with enable=1 restarts cleanly.
- DONE: `run`=0 and `count` is held. A CTRL write with enable=1 restarts; enable=0 moves to IDLE.

Patterns, with n = sample index from 0:
- Ramp: I=n[15:0], Q=~n[15:0]. Wraps at 65535→0.
- Constant: `sample`=SEED.
- LFSR: Fibonacci LFSR, taps 32,22,2,1, shifting left. The first sample is the seed; the register advances once per strobe.
- Toggle: alternates 0x7FFF_8001 and 0x8001_7FFF, starting with 0x7FFF_8001.

Other rules:
- Writes to PERIOD, SEED and NUM during RUN take effect at the next restart only; the active copies are latched at start.
- Addresses outside BASE..BASE+3 are ignored.

## Timing
- Reset values: `sample`=0, `strobe`=0, `run`=0, `count`=0, state IDLE.
- Start to first strobe:
  - The CTRL write is seen at edge k; `run`=1 from edge k+1.
  - The first strobe is in the cycle after edge k+1. Latency is exactly 2 cycles from set_stb high to first strobe, independent of PERIOD.
- Strobe spacing: PERIOD+1 cycles.
- `sample` is registered, changes only on strobe cycles, and holds between strobes.
- `count` increments in the cycle after each strobe.
- Restart and stop:
  - A CTRL write coinciding with a would-be strobe cycle suppresses that strobe; the restart/stop wins.
  - In IDLE and DONE, `sample` holds its last value.
- Reset asserted mid-run forces all reset values asynchronously. After deassertion the source stays IDLE until a CTRL write.

## Structure
- A shared package holds:
  - register offsets (CTRL=0, PERIOD=1, SEED=2, NUM=3);
  - mode encodings;
  - state encodings (IDLE, RUN, DONE);
  - LFSR tap mask 32'h8020_0003;
  - toggle words.
- Settings registers use the existing `setting_reg`. Its synchronous active-high reset is driven from the inverted local reset; the CTRL write pulse is decoded locally.
- One natural sub-module: `qa_lfsr32`, with load and advance inputs and a 32-bit state output, seed 0 forced to 1.

## Test plan
- Ramp, PERIOD=3, NUM=5, enable:
  - first strobe 2 cycles after the write, then every 4 cycles;
  - samples 0x0000FFFF, 0x0001FFFE, 0x0002FFFD, 0x0003FFFC, 0x0004FFFB;
  - then DONE, `run`=0, `count`=5.
- Constant, SEED=0xDEADBEEF, PERIOD=0, NUM=0: strobe every cycle, `sample`=0xDEADBEEF; a CTRL write with enable=0 gives no further strobe and `run`=0 the next cycle.
- LFSR, SEED=0: the first sample is 0x00000001 and each following sample matches the reference model for 1000 strobes; rerunning with the same seed reproduces the sequence.
- Ramp continuous for 65537 strobes: I wraps to 0x0000 at index 65536; `count`=65537.
- Reset pulled low mid-run at an arbitrary cycle: all outputs are 0 immediately; after release there is no strobe until a new enable write.
- PERIOD rewritten during RUN: spacing is unchanged until a restart, after which the new spacing applies; a CTRL write on a strobe cycle suppresses that strobe.
